// File: rtl/uart_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer_pkg
// Purpose  : Shared UART definitions: FSM state codes, parity codes and
//            the data-length clamp helper.
// Revision : 1.0  initial release
// ============================================================================
package uart_tx_serializer_pkg;

    // Serializer FSM state codes (3-bit)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_BREAK  = 3'd6
    } tx_state_t;

    // Parity selection codes
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10,
        PAR_MARK = 2'b11
    } parity_t;

    localparam logic [3:0] c_min_data_len = 4'd5;

    // Force the requested length into the legal window [5, max_len]
    function automatic logic [3:0] clamp_len(input logic [3:0] len,
                                             input logic [3:0] max_len);
        logic [3:0] res;
        res = len;
        if (len < c_min_data_len) begin
            res = c_min_data_len;
        end else if (len > max_len) begin
            res = max_len;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous first-word-fall-through word buffer with occupancy
//            count and a registered overflow pulse on dropped writes.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              rd_en,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH):0]       count,
    output logic                              overflow
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] c_depth = (FIFO_AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;

    // Fullness comes from the registered count, so a same-cycle pop never
    // makes room for a write.
    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign w_push   = wr_en && !full;
    assign w_pop    = rd_en && !empty;
    assign rd_data  = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;

    // Storage array; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer, occupancy and overflow bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= wr_en && full;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : UART transmit serializer. Buffers words in uart_tx_fifo and
//            emits back-to-back frames (start, 5..DATA_W data bits LSB first,
//            optional parity, 1 or 2 stop bits), one bit per baud_clk edge.
// Options  : TX_BREAK_EN - adds send_break input for line-break generation.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter  int DATA_W     = 9,
    parameter  int FIFO_DEPTH = 4,
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic               baud_clk,
    input  logic               arst_n,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ready,
    input  logic [3:0]         data_len,
    input  logic [1:0]         parity_type,
    input  logic               stop_bits,
`ifdef TX_BREAK_EN
    input  logic               send_break,
`endif
    output logic               tx,
    output logic               tx_active,
    output logic               tx_done,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_len;
    logic [3:0]        r_bit_cnt;
    parity_t           r_par;
    logic              r_stop2;
    logic              r_par_acc;
    logic              r_tx;
    logic              r_tx_active;
    logic              r_tx_done;

    logic              w_tx_nxt;
    logic              w_active_nxt;
    logic              w_done_nxt;
    logic              w_pop;
    logic              w_last_stop;
    logic              w_break_req;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_full;
    logic              w_empty;

`ifdef TX_BREAK_EN
    assign w_break_req = send_break;
`else
    assign w_break_req = 1'b0;
`endif

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (baud_clk),
        .rst_n    (arst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (w_pop),
        .rd_data  (w_rd_data),
        .full     (w_full),
        .empty    (w_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign wr_ready  = !w_full;
    assign tx        = r_tx;
    assign tx_active = r_tx_active;
    assign tx_done   = r_tx_done;

    // FSM state register
    always_ff @(posedge baud_clk) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the line value for the bit this state represents;
    // the line value is registered, so tx trails the state by one edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = 1'b1;
        w_active_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_pop        = 1'b0;
        w_last_stop  = (r_state == S_STOP2) || ((r_state == S_STOP1) && !r_stop2);
        case (r_state)
            S_IDLE: begin
                if (w_break_req) begin
                    w_state_nxt = S_BREAK;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_BREAK: begin
                w_tx_nxt = 1'b0;
                if (!w_break_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_tx_nxt     = 1'b0;
                w_active_nxt = 1'b1;
                w_state_nxt  = S_DATA;
            end
            S_DATA: begin
                w_tx_nxt     = r_shift[0];
                w_active_nxt = 1'b1;
                if (r_bit_cnt == r_len - 4'd1) begin
                    w_state_nxt = (r_par != PAR_NONE) ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                w_active_nxt = 1'b1;
                w_state_nxt  = S_STOP1;
                case (r_par)
                    PAR_EVEN: w_tx_nxt = r_par_acc;
                    PAR_ODD:  w_tx_nxt = ~r_par_acc;
                    default:  w_tx_nxt = 1'b1;
                endcase
            end
            S_STOP1, S_STOP2: begin
                w_active_nxt = 1'b1;
                if (w_last_stop) begin
                    w_done_nxt = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_STOP2;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output registers, frame config latch at pop, and data shifter
    always_ff @(posedge baud_clk) begin
        if (!arst_n) begin
            r_tx        <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
            r_shift     <= '0;
            r_len       <= c_min_data_len;
            r_bit_cnt   <= '0;
            r_par       <= PAR_NONE;
            r_stop2     <= 1'b0;
            r_par_acc   <= 1'b0;
        end else begin
            r_tx        <= w_tx_nxt;
            r_tx_active <= w_active_nxt;
            r_tx_done   <= w_done_nxt;
            if (w_pop) begin
                r_shift   <= w_rd_data;
                r_len     <= clamp_len(data_len, 4'(DATA_W));
                r_par     <= parity_t'(parity_type);
                r_stop2   <= stop_bits;
                r_par_acc <= 1'b0;
            end else if (r_state == S_DATA) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_par_acc <= r_par_acc ^ r_shift[0];
            end
            if (r_state == S_START) begin
                r_bit_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Purpose  : Directed self-checking bench for uart_tx_serializer.
//            Frame bit vectors are written in time order (leftmost = first).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_serializer;

    logic       baud_clk = 1'b0;
    logic       arst_n;
    logic       wr_en;
    logic [8:0] wr_data;
    logic       wr_ready;
    logic [3:0] data_len;
    logic [1:0] parity_type;
    logic       stop_bits;
`ifdef TX_BREAK_EN
    logic       send_break;
`endif
    logic       tx;
    logic       tx_active;
    logic       tx_done;
    logic [2:0] fifo_count;
    logic       overflow;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] cnt_log [32];

    uart_tx_serializer #(
        .DATA_W     (9),
        .FIFO_DEPTH (4)
    ) dut (
        .baud_clk    (baud_clk),
        .arst_n      (arst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .data_len    (data_len),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
`ifdef TX_BREAK_EN
        .send_break  (send_break),
`endif
        .tx          (tx),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one word across a single rising edge; returns at the next negedge
    task automatic push(input logic [8:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge baud_clk);
        wr_en   = 1'b0;
    endtask

    task automatic config_frame(input logic [3:0] len, input logic [1:0] par, input logic stp);
        data_len    = len;
        parity_type = par;
        stop_bits   = stp;
    endtask

    // Wait for tx_active, record n cycles, then require the line to be idle
    task automatic capture(input string tag, input int n, input logic [31:0] exp_tx,
                           input logic [31:0] exp_done, output int wait_cyc);
        logic [31:0] txv;
        logic [31:0] actv;
        logic [31:0] donev;
        int          w;
        txv = '0; actv = '0; donev = '0; w = 0;
        while (!tx_active && w < 40) begin
            @(negedge baud_clk);
            w++;
        end
        for (int i = 0; i < n; i++) begin
            cnt_log[i] = fifo_count;
            txv   = {txv[30:0], tx};
            actv  = {actv[30:0], tx_active};
            donev = {donev[30:0], tx_done};
            @(negedge baud_clk);
        end
        check({tag, "_tx"},     txv,   exp_tx);
        check({tag, "_active"}, actv,  (32'd1 << n) - 32'd1);
        check({tag, "_done"},   donev, exp_done);
        check({tag, "_end"},    32'(tx_active), 32'd0);
        wait_cyc = w;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int w;
        w = 0;
        while ((tx_active || fifo_count != 3'd0) && w < budget) begin
            @(negedge baud_clk);
            w++;
        end
        check(tag, 32'({tx_active, fifo_count}), 32'd0);
    endtask

    initial begin
        int lat;
        int act_cnt;
        arst_n  = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        config_frame(4'd8, 2'b00, 1'b0);
`ifdef TX_BREAK_EN
        send_break = 1'b0;
`endif
        repeat (2) @(negedge baud_clk);
        check("rst_tx",       32'(tx),         32'd1);
        check("rst_active",   32'(tx_active),  32'd0);
        check("rst_done",     32'(tx_done),    32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_count",    32'(fifo_count), 32'd0);
        check("rst_ready",    32'(wr_ready),   32'd1);
        arst_n = 1'b1;
        @(negedge baud_clk);

        // 0xA5, 8 bits, even parity, one stop: 0 10100101 0 1
        config_frame(4'd8, 2'b10, 1'b0);
        push(9'h0A5);
        check("t1_count", 32'(fifo_count), 32'd1);
        capture("t1", 11, 32'b01010010101, 32'b00000000001, lat);
        check("t1_latency", 32'(lat), 32'd2);

        // 0x1F, 5 bits, odd parity, two stops: 0 11111 0 1 1
        config_frame(4'd5, 2'b01, 1'b1);
        push(9'h01F);
        capture("t2", 9, 32'b011111011, 32'b000000001, lat);

        // Length below minimum clamps to 5; upper word bits ignored
        config_frame(4'd2, 2'b00, 1'b0);
        push(9'h1F5);
        capture("clamp_lo", 7, 32'b0101011, 32'b0000001, lat);

        // Length above DATA_W clamps to 9; mark parity: 0 110101011 1 1
        config_frame(4'd15, 2'b11, 1'b0);
        push(9'h1AB);
        capture("clamp_hi", 12, 32'b011010101111, 32'b000000000001, lat);

        // Three words on consecutive edges -> three 10-bit frames back-to-back
        config_frame(4'd8, 2'b00, 1'b0);
        push(9'h001);
        check("t3_cnt_a", 32'(fifo_count), 32'd1);
        push(9'h080);
        check("t3_cnt_b", 32'(fifo_count), 32'd1);
        push(9'h03C);
        check("t3_cnt_c", 32'(fifo_count), 32'd2);
        capture("t3", 30, 32'b010000000100000000110001111001,
                          32'b000000000100000000010000000001, lat);
        check("t3_cnt_mid1", 32'(cnt_log[8]),  32'd2);
        check("t3_cnt_mid2", 32'(cnt_log[9]),  32'd1);
        check("t3_cnt_last", 32'(cnt_log[19]), 32'd0);

        // Fill the FIFO while a 13-cycle frame is in flight
        config_frame(4'd9, 2'b10, 1'b1);
        push(9'h100);
        lat = 0;
        while (!tx_active && lat < 40) begin
            @(negedge baud_clk);
            lat++;
        end
        push(9'h011);
        check("t4_cnt1", 32'(fifo_count), 32'd1);
        push(9'h022);
        check("t4_cnt2", 32'(fifo_count), 32'd2);
        push(9'h033);
        check("t4_cnt3", 32'(fifo_count), 32'd3);
        check("t4_ready3", 32'(wr_ready), 32'd1);
        push(9'h044);
        check("t4_cnt4", 32'(fifo_count), 32'd4);
        check("t4_ready4", 32'(wr_ready), 32'd0);
        check("t4_ovf_pre", 32'(overflow), 32'd0);
        push(9'h055);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_cnt5", 32'(fifo_count), 32'd4);
        @(negedge baud_clk);
        check("t4_ovf_clear", 32'(overflow), 32'd0);
        wait_idle("t4_drain", 200);

        // Config change mid-frame: 0x0F keeps 8 bits, 0x3F goes out with 6
        config_frame(4'd8, 2'b00, 1'b0);
        push(9'h00F);
        push(9'h03F);
        data_len = 4'd6;
        capture("t5", 18, 32'b011110000101111111, 32'b000000000100000001, lat);

        // Reset during DATA with two words queued
        config_frame(4'd8, 2'b00, 1'b0);
        push(9'h0AA);
        push(9'h0BB);
        push(9'h0CC);
        check("t6_cnt", 32'(fifo_count), 32'd2);
        arst_n = 1'b0;
        @(negedge baud_clk);
        check("t6_tx",     32'(tx),         32'd1);
        check("t6_active", 32'(tx_active),  32'd0);
        check("t6_count",  32'(fifo_count), 32'd0);
        arst_n  = 1'b1;
        act_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge baud_clk);
            if (tx_active || !tx) act_cnt++;
        end
        check("t6_quiet", 32'(act_cnt), 32'd0);

`ifdef TX_BREAK_EN
        // 20-cycle break with a word queued: 1, 20x0, one idle 1, then start
        begin
            logic [31:0] txv;
            logic [31:0] actv;
            txv  = '0;
            actv = '0;
            config_frame(4'd8, 2'b00, 1'b0);
            send_break = 1'b1;
            wr_data    = 9'h055;
            wr_en      = 1'b1;
            for (int i = 0; i < 23; i++) begin
                @(negedge baud_clk);
                txv  = {txv[30:0], tx};
                actv = {actv[30:0], tx_active};
                if (i == 0)  wr_en      = 1'b0;
                if (i == 19) send_break = 1'b0;
            end
            check("t7_tx",     txv,  32'b10000000000000000000010);
            check("t7_active", actv, 32'b00000000000000000000001);
            wait_idle("t7_drain", 40);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
